he_lb_test_seq: RTL and testbench
=================================

# he_lb_test_seq

Hardware sequencer that runs one host-exerciser loopback (HE-LB) test pass over an MMIO master port. It sits between a test controller, which pulses `start` with the buffer addresses and line count, and the HE-LB CSR block. On each run it reads INFO0, programs the CSRs in a fixed order, starts the engine and polls completion with a timeout. It then reads ERROR and reports one status code. It replaces host-driven CSR sequencing in unit benches and in self-test builds.

## Interface
- `BASE_ADDR`, 20'h0: byte offset of the HE-LB CSR window; added to every CSR offset.
- `POLL_GAP`, 64: idle cycles between STATUS0 polls (1..65535).
- `TIMEOUT_POLLS`, 4096: STATUS0 reads allowed before the run times out (≥1).
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; accepted only in IDLE.
- `abort` in 1: level; stops an active run.
- `src_addr` in 64: source buffer address, sampled on `start`.
- `dst_addr` in 64: destination buffer address, sampled on `start`.
- `dsm_addr` in 64: DSM base address, sampled on `start`.
- `num_lines` in 32: cache lines to move, sampled on `start`.
- `cfg` in 64: value written to CFG, sampled on `start`.
- `req_valid` out 1: MMIO request valid.
- `req_ready` in 1: MMIO request ready.
- `req_write` out 1: 1 = write, 0 = read.
- `req_addr` out 20: byte address.
- `req_wdata` out 64: write data.
- `rsp_valid` in 1: read data valid (one cycle).
- `rsp_data` in 64: read data.
- `busy` out 1: high from `start` accepted until `done`.
- `done` out 1: one-cycle pulse at end of run.
- `done_status` out 3: 0 pass, 1 ERROR≠0, 2 timeout, 3 aborted, 4 bad config. Held until the next `start`.
- `bus_bytes` out 8: `32 << INFO0[17:16]`, captured from the INFO0 read.
- `polls` out 16: STATUS0 reads issued in the last run.

## Operation
- CSR offsets: CTL 0x138, SRC_ADDR 0x120, DST_ADDR 0x128, NUM_LINES 0x130, CFG 0x140, DSM_BASEL 0x110, DSM_BASEH 0x114, STATUS0 0x160, ERROR 0x170, INFO0 0x180.
- States: IDLE → RD_INFO → WR_SEQ → POLL_RD → POLL_GAP ↺ → RD_ERR → WR_STOP → DONE → IDLE.
- `start` in IDLE with `num_lines==0`: go straight to DONE with status 4. No MMIO traffic is issued.
- RD_INFO: read INFO0 and capture `bus_bytes`.
- WR_SEQ: 4-bit step counter drives 8 writes, in this order:
  - CTL=0
  - CTL=1
  - SRC_ADDR
  - DST_ADDR
  - NUM_LINES=`{32'h0,num_lines}`
  - CFG
  - DSM_BASEL=`{32'h0,dsm[31:0]}`
  - DSM_BASEH=`{32'h0,dsm[63:32]}`
  - followed by CTL=3 (start engine).
- POLL_RD: read STATUS0 and increment `polls`.
  - If `rsp_data[31:0] >= num_lines` (unsigned), go to RD_ERR.
  - Otherwise, if `polls == TIMEOUT_POLLS`, set status 2 and go to WR_STOP.
  - Otherwise go to POLL_GAP: count POLL_GAP cycles, then return to POLL_RD.
- RD_ERR: read ERROR; status is 1 if nonzero, else 0.
- WR_STOP: write CTL=0, then DONE.
- DONE: pulse `done` for one cycle, clear `busy`, return to IDLE.
- Only one transaction is outstanding at a time.
- `abort` seen in any state other than IDLE/WR_STOP/DONE:
  - Finish any accepted-but-unanswered read first (wait for `rsp_valid`).
  - Never drop an asserted `req_valid` before its handshake.
  - Then go to WR_STOP with status 3.
- `start` while `busy`: ignored.

## Timing
- Reset values: state IDLE; `req_valid=0`, `req_write=0`, `req_addr=0`, `req_wdata=0`, `busy=0`, `done=0`, `done_status=0`, `bus_bytes=32`, `polls=0`.
- Handshake: a request transfers on `req_valid & req_ready`.
  - `req_valid/write/addr/wdata` are registered and held stable until that transfer.
  - `req_valid` drops on the cycle after the transfer.
- Write completion: a write is complete at its handshake; the next request may assert on the next cycle.
- Read completion: the FSM waits for `rsp_valid`.
  - `rsp_valid` may arrive any time ≥1 cycle after the handshake.
  - `rsp_valid` outside a read wait is ignored.
- `start` to first `req_valid`: 1 cycle.
- Bad-config run: `start` at cycle N gives `done` at N+2.
- `polls` and the gap counter saturate; they do not wrap.
- `busy` rises the cycle after `start` and falls together with `done`.
- `rst` asserted mid-run: return to IDLE on the next edge with reset values. No CTL=0 write is issued.

## Test plan
- `num_lines=16`, `req_ready=1`, 2-cycle read latency, INFO0[17:16]=2, STATUS0=16 on the 3rd poll → exactly 10 writes in the order above and 3 polls, then `done_status=0`, `bus_bytes=128`, `polls=3`.
- `num_lines=0` → no `req_valid`, `done` 2 cycles after `start`, status 4.
- STATUS0 stuck at 5, `TIMEOUT_POLLS=4` → 4 polls spaced ≥POLL_GAP cycles, then CTL=0 write, status 2.
- ERROR reads 0x1 → CTL=0 write, status 1.
- `abort` raised while `req_ready=0` holds the NUM_LINES write → that write completes, then CTL=0 write, status 3, `busy` low.
- `req_ready` randomly toggled with random read latency → request fields stable while stalled; `start` pulses during `busy` are ignored; `rst` mid-poll returns to IDLE with all outputs at reset values.

Source files
------------

// File: rtl/he_lb_test_seq.sv
// he_lb_test_seq: runs one HE-LB loopback pass over an MMIO master port.
// Reads INFO0, programs CSRs, starts the engine, polls STATUS0, reads ERROR.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, abort          run request pulse, abort level
//   src_addr .. cfg       run parameters, sampled on an accepted start
//   req_* / rsp_*         MMIO request (valid/ready) and read response
//   busy, done            run in progress, one-cycle end-of-run pulse
//   done_status           0 pass, 1 error, 2 timeout, 3 aborted, 4 bad config
//   bus_bytes, polls      INFO0 bus width, STATUS0 reads of the last run
module he_lb_test_seq #(
  parameter logic [19:0] BASE_ADDR     = 20'h0,
  parameter int unsigned POLL_GAP      = 64,
  parameter int unsigned TIMEOUT_POLLS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] src_addr,
  input  logic [63:0] dst_addr,
  input  logic [63:0] dsm_addr,
  input  logic [31:0] num_lines,
  input  logic [63:0] cfg,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic [19:0] req_addr,
  output logic [63:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [63:0] rsp_data,
  output logic        busy,
  output logic        done,
  output logic [2:0]  done_status,
  output logic [7:0]  bus_bytes,
  output logic [15:0] polls
);

  localparam logic [19:0] A_CTL  = BASE_ADDR + 20'h138;
  localparam logic [19:0] A_SRC  = BASE_ADDR + 20'h120;
  localparam logic [19:0] A_DST  = BASE_ADDR + 20'h128;
  localparam logic [19:0] A_NUM  = BASE_ADDR + 20'h130;
  localparam logic [19:0] A_CFG  = BASE_ADDR + 20'h140;
  localparam logic [19:0] A_DSML = BASE_ADDR + 20'h110;
  localparam logic [19:0] A_DSMH = BASE_ADDR + 20'h114;
  localparam logic [19:0] A_STAT = BASE_ADDR + 20'h160;
  localparam logic [19:0] A_ERR  = BASE_ADDR + 20'h170;
  localparam logic [19:0] A_INFO = BASE_ADDR + 20'h180;

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_INFO,
    S_WR_SEQ,
    S_POLL_RD,
    S_POLL_GAP,
    S_RD_ERR,
    S_WR_STOP,
    S_DONE
  } state_t;

  state_t      state;
  logic [3:0]  step;
  logic [15:0] gap;
  logic        rd_wait;
  logic        abort_q;
  logic [2:0]  stat;
  logic [63:0] src_q;
  logic [63:0] dst_q;
  logic [63:0] dsm_q;
  logic [63:0] cfg_q;
  logic [31:0] lines_q;

  logic        active;
  logic        ab;
  logic        iss_write;
  logic [19:0] iss_addr;
  logic [63:0] iss_wdata;

  // abort is remembered so a request already in flight can finish first
  assign active = (state != S_IDLE) && (state != S_WR_STOP) &&
                  (state != S_DONE);
  assign ab = abort | abort_q;

  // Fields of the next request to issue from the current state
  always_comb begin
    iss_write = 1'b0;
    iss_addr  = A_INFO;
    iss_wdata = 64'd0;
    case (state)
      S_WR_SEQ: begin
        iss_write = 1'b1;
        case (step)
          4'd0: begin iss_addr = A_CTL; iss_wdata = 64'd0; end
          4'd1: begin iss_addr = A_CTL; iss_wdata = 64'd1; end
          4'd2: begin iss_addr = A_SRC; iss_wdata = src_q; end
          4'd3: begin iss_addr = A_DST; iss_wdata = dst_q; end
          4'd4: begin
            iss_addr  = A_NUM;
            iss_wdata = {32'h0, lines_q};
          end
          4'd5: begin iss_addr = A_CFG; iss_wdata = cfg_q; end
          4'd6: begin
            iss_addr  = A_DSML;
            iss_wdata = {32'h0, dsm_q[31:0]};
          end
          4'd7: begin
            iss_addr  = A_DSMH;
            iss_wdata = {32'h0, dsm_q[63:32]};
          end
          default: begin iss_addr = A_CTL; iss_wdata = 64'd3; end
        endcase
      end
      S_POLL_RD: iss_addr = A_STAT;
      S_RD_ERR:  iss_addr = A_ERR;
      S_WR_STOP: begin
        iss_write = 1'b1;
        iss_addr  = A_CTL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= 4'd0;
      gap         <= 16'd0;
      rd_wait     <= 1'b0;
      abort_q     <= 1'b0;
      stat        <= 3'd0;
      src_q       <= 64'd0;
      dst_q       <= 64'd0;
      dsm_q       <= 64'd0;
      cfg_q       <= 64'd0;
      lines_q     <= 32'd0;
      req_valid   <= 1'b0;
      req_write   <= 1'b0;
      req_addr    <= 20'd0;
      req_wdata   <= 64'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_status <= 3'd0;
      bus_bytes   <= 8'd32;
      polls       <= 16'd0;
    end else begin
      done <= 1'b0;
      if (abort && active) abort_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            dsm_q   <= dsm_addr;
            cfg_q   <= cfg;
            lines_q <= num_lines;
            polls   <= 16'd0;
            step    <= 4'd0;
            rd_wait <= 1'b0;
            busy    <= 1'b1;
            if (num_lines == 32'd0) begin
              stat  <= 3'd4;
              state <= S_DONE;
            end else begin
              stat      <= 3'd0;
              state     <= S_RD_INFO;
              req_valid <= 1'b1;
              req_write <= iss_write;
              req_addr  <= iss_addr;
              req_wdata <= iss_wdata;
            end
          end
        end
        S_RD_INFO: begin
          if (req_valid) begin
            if (req_ready) begin
              req_valid <= 1'b0;
              rd_wait   <= 1'b1;
            end
          end else if (rd_wait && rsp_valid) begin
            rd_wait   <= 1'b0;
            bus_bytes <= 8'd32 << rsp_data[17:16];
            if (ab) begin
              stat  <= 3'd3;
              state <= S_WR_STOP;
            end else begin
              state <= S_WR_SEQ;
            end
          end
        end
        S_WR_SEQ: begin
          if (req_valid) begin
            if (req_ready) begin
              req_valid <= 1'b0;
              if (step == 4'd8) begin
                step  <= 4'd0;
                state <= S_POLL_RD;
              end else begin
                step <= step + 4'd1;
              end
            end
          end else if (ab) begin
            stat  <= 3'd3;
            state <= S_WR_STOP;
          end else begin
            req_valid <= 1'b1;
            req_write <= iss_write;
            req_addr  <= iss_addr;
            req_wdata <= iss_wdata;
          end
        end
        S_POLL_RD: begin
          if (req_valid) begin
            if (req_ready) begin
              req_valid <= 1'b0;
              rd_wait   <= 1'b1;
              if (polls != 16'hFFFF) polls <= polls + 16'd1;
            end
          end else if (rd_wait) begin
            if (rsp_valid) begin
              rd_wait <= 1'b0;
              if (ab) begin
                stat  <= 3'd3;
                state <= S_WR_STOP;
              end else if (rsp_data[31:0] >= lines_q) begin
                state <= S_RD_ERR;
              end else if ({16'h0, polls} == TIMEOUT_POLLS) begin
                stat  <= 3'd2;
                state <= S_WR_STOP;
              end else begin
                gap   <= 16'd0;
                state <= S_POLL_GAP;
              end
            end
          end else if (ab) begin
            stat  <= 3'd3;
            state <= S_WR_STOP;
          end else begin
            req_valid <= 1'b1;
            req_write <= iss_write;
            req_addr  <= iss_addr;
            req_wdata <= iss_wdata;
          end
        end
        S_POLL_GAP: begin
          if (ab) begin
            stat  <= 3'd3;
            state <= S_WR_STOP;
          end else if (gap >= GAP_LAST) begin
            state <= S_POLL_RD;
          end else begin
            gap <= gap + 16'd1;
          end
        end
        S_RD_ERR: begin
          if (req_valid) begin
            if (req_ready) begin
              req_valid <= 1'b0;
              rd_wait   <= 1'b1;
            end
          end else if (rd_wait) begin
            if (rsp_valid) begin
              rd_wait <= 1'b0;
              state   <= S_WR_STOP;
              if (ab) stat <= 3'd3;
              else stat <= (rsp_data != 64'd0) ? 3'd1 : 3'd0;
            end
          end else if (ab) begin
            stat  <= 3'd3;
            state <= S_WR_STOP;
          end else begin
            req_valid <= 1'b1;
            req_write <= iss_write;
            req_addr  <= iss_addr;
            req_wdata <= iss_wdata;
          end
        end
        S_WR_STOP: begin
          if (req_valid) begin
            if (req_ready) begin
              req_valid <= 1'b0;
              state     <= S_DONE;
            end
          end else begin
            req_valid <= 1'b1;
            req_write <= iss_write;
            req_addr  <= iss_addr;
            req_wdata <= iss_wdata;
          end
        end
        S_DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          done_status <= stat;
          abort_q     <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_he_lb_test_seq.sv
// tb_he_lb_test_seq: directed bench for he_lb_test_seq.
// CSR responder plus an expected-transaction model built per run.
module tb_he_lb_test_seq;

  localparam logic [19:0] BASE = 20'h04000;
  localparam int GAP = 8;
  localparam int TMO = 4;

  localparam logic [19:0] A_CTL  = BASE + 20'h138;
  localparam logic [19:0] A_SRC  = BASE + 20'h120;
  localparam logic [19:0] A_DST  = BASE + 20'h128;
  localparam logic [19:0] A_NUM  = BASE + 20'h130;
  localparam logic [19:0] A_CFG  = BASE + 20'h140;
  localparam logic [19:0] A_DSML = BASE + 20'h110;
  localparam logic [19:0] A_DSMH = BASE + 20'h114;
  localparam logic [19:0] A_STAT = BASE + 20'h160;
  localparam logic [19:0] A_ERR  = BASE + 20'h170;
  localparam logic [19:0] A_INFO = BASE + 20'h180;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [63:0] src_addr = '0;
  logic [63:0] dst_addr = '0;
  logic [63:0] dsm_addr = '0;
  logic [31:0] num_lines = '0;
  logic [63:0] cfg = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic        req_write;
  logic [19:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid = 1'b0;
  logic [63:0] rsp_data = '0;
  logic        busy;
  logic        done;
  logic [2:0]  done_status;
  logic [7:0]  bus_bytes;
  logic [15:0] polls;

  he_lb_test_seq #(
    .BASE_ADDR(BASE),
    .POLL_GAP(GAP),
    .TIMEOUT_POLLS(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .dsm_addr(dsm_addr),
    .num_lines(num_lines), .cfg(cfg),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .done(done), .done_status(done_status),
    .bus_bytes(bus_bytes), .polls(polls)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  int          rdy_mode = 0;
  int          lat_lo = 2;
  int          lat_hi = 2;
  bit          hold_num = 0;
  logic [63:0] info_val = '0;
  logic [63:0] err_val = '0;
  logic [31:0] lines_val = '0;
  int          hit_poll = -1;
  int          poll_idx = 0;
  int          last_poll = 0;
  int          rsp_cnt = 0;
  logic [63:0] rsp_pend = '0;
  int          cyc = 0;
  bit          prev_hs = 0;
  bit          prev_stall = 0;
  logic        st_write;
  logic [19:0] st_addr;
  logic [63:0] st_wdata;

  function automatic void chk(input string nm, input logic [63:0] a,
                              input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
    end
  endfunction

  function automatic void push(input bit wr, input logic [19:0] a,
                               input logic [63:0] d);
    exp_t e;
    e.wr = wr;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic logic [7:0] bb_of(input logic [63:0] info);
    int k;
    k = int'(info[17:16]);
    return 8'((32 * (2 ** k)) % 256);
  endfunction

  // Expected MMIO sequence, final status and poll count for one run
  task automatic build(input logic [63:0] s, input logic [63:0] d,
                       input logic [63:0] m, input logic [63:0] c,
                       input logic [31:0] n, input int hit,
                       input logic [63:0] err, input int cut,
                       output int st, output int np);
    bit timed;
    exp_q.delete();
    push(0, A_INFO, '0);
    push(1, A_CTL, 64'd0);
    push(1, A_CTL, 64'd1);
    push(1, A_SRC, s);
    push(1, A_DST, d);
    push(1, A_NUM, {32'h0, n});
    push(1, A_CFG, c);
    push(1, A_DSML, {32'h0, m[31:0]});
    push(1, A_DSMH, {32'h0, m[63:32]});
    push(1, A_CTL, 64'd3);
    np = 0;
    timed = 1;
    for (int i = 0; i < TMO; i++) begin
      push(0, A_STAT, '0);
      np = i + 1;
      if (i == hit) begin
        timed = 0;
        break;
      end
    end
    if (!timed) push(0, A_ERR, '0);
    push(1, A_CTL, 64'd0);
    st = timed ? 2 : ((err != 0) ? 1 : 0);
    if (cut >= 0) begin
      exp_q = exp_q[0:cut-1];
      push(1, A_CTL, 64'd0);
      st = 3;
      np = 0;
      foreach (exp_q[i])
        if (!exp_q[i].wr && exp_q[i].addr == A_STAT) np++;
    end
  endtask

  // CSR responder and handshake checker, all on the falling edge
  task automatic handle_req();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL extra_req: got addr %h write %0d expected none",
               req_addr, req_write);
    end else begin
      e = exp_q.pop_front();
      chk("req_write", 64'(req_write), 64'(e.wr));
      chk("req_addr", 64'(req_addr), 64'(e.addr));
      if (e.wr) chk("req_wdata", req_wdata, e.data);
    end
    if (!req_write) begin
      if (req_addr == A_INFO) rsp_pend = info_val;
      else if (req_addr == A_ERR) rsp_pend = err_val;
      else if (req_addr == A_STAT) begin
        if (poll_idx == hit_poll) rsp_pend = {32'hABCD_0000, lines_val};
        else rsp_pend = {32'hFFFF_FFFF, 32'd5};
        if (poll_idx > 0)
          chk("poll_spacing", 64'((cyc - last_poll) >= GAP), 64'd1);
        last_poll = cyc;
        poll_idx++;
      end else rsp_pend = '0;
      rsp_cnt = $urandom_range(lat_hi, lat_lo);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rsp_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data = rsp_pend;
        end
      end
      if (rdy_mode == 1) req_ready = 1'($urandom_range(1, 0));
      else req_ready = 1'b1;
      if (hold_num && req_addr == A_NUM) req_ready = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", 64'(req_valid), 64'd1);
        chk("stall_write", 64'(req_write), 64'(st_write));
        chk("stall_addr", 64'(req_addr), 64'(st_addr));
        chk("stall_wdata", req_wdata, st_wdata);
      end
      if (prev_hs) chk("valid_drop", 64'(req_valid), 64'd0);
      prev_hs = req_valid && req_ready;
      prev_stall = req_valid && !req_ready;
      st_write = req_write;
      st_addr = req_addr;
      st_wdata = req_wdata;
      if (prev_hs) handle_req();
    end
  end

  task automatic chk_reset_vals();
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_req_write", 64'(req_write), 64'd0);
    chk("rst_req_addr", 64'(req_addr), 64'd0);
    chk("rst_req_wdata", req_wdata, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_done_status", 64'(done_status), 64'd0);
    chk("rst_bus_bytes", 64'(bus_bytes), 64'd32);
    chk("rst_polls", 64'(polls), 64'd0);
  endtask

  task automatic do_start(input logic [63:0] s, input logic [63:0] d,
                          input logic [63:0] m, input logic [63:0] c,
                          input logic [31:0] n);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    dsm_addr = m;
    cfg = c;
    num_lines = n;
    lines_val = n;
    poll_idx = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    chk("first_req", 64'(req_valid), 64'(n != 0));
  endtask

  task automatic wait_done(input int budget, input bit noise,
                           output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
      if (!busy) chk("busy_run", 64'(busy), 64'd1);
      if (noise) start = (k % 7 == 3);
    end
    start = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no done expected done within %0d",
               budget);
    end
  endtask

  task automatic end_checks(input int st, input int np,
                            input logic [7:0] bb, input bit use_bb);
    chk("done_status", 64'(done_status), 64'(st));
    chk("polls", 64'(polls), 64'(np));
    chk("busy_fall", 64'(busy), 64'd0);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
    if (use_bb) chk("bus_bytes", 64'(bus_bytes), 64'(bb));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    int st;
    int np;
    int w;
    bit ok;
    bit saw;

    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    // Nominal pass: 3 polls, 2-cycle read latency
    info_val = 64'h0000_0000_0002_0000;
    err_val = '0;
    hit_poll = 2;
    build(64'h1111_2222_3333_4440, 64'h5555_6666_7777_8880,
          64'hAAAA_BBBB_CCCC_D000, 64'h0000_0000_0000_0042,
          32'd16, 2, '0, -1, st, np);
    w = 0;
    foreach (exp_q[i]) if (exp_q[i].wr) w++;
    chk("model_len", 64'(exp_q.size()), 64'd15);
    chk("model_writes", 64'(w), 64'd10);
    do_start(64'h1111_2222_3333_4440, 64'h5555_6666_7777_8880,
             64'hAAAA_BBBB_CCCC_D000, 64'h0000_0000_0000_0042, 32'd16);
    wait_done(2000, 0, ok);
    chk("t1_status", 64'(done_status), 64'd0);
    chk("t1_bus_bytes", 64'(bus_bytes), 64'd128);
    chk("t1_polls", 64'(polls), 64'd3);
    end_checks(st, np, bb_of(info_val), 1);

    // Bad config: no traffic, done two cycles after start
    exp_q.delete();
    do_start(64'h1, 64'h2, 64'h3, 64'h4, 32'd0);
    chk("bad_done_early", 64'(done), 64'd0);
    @(negedge clk);
    chk("bad_done", 64'(done), 64'd1);
    chk("bad_status", 64'(done_status), 64'd4);
    chk("bad_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("bad_done_pulse", 64'(done), 64'd0);

    // Timeout: STATUS0 stuck below num_lines
    hit_poll = -1;
    build(64'h100, 64'h200, 64'h300, 64'h7, 32'd16, -1, '0, -1, st, np);
    do_start(64'h100, 64'h200, 64'h300, 64'h7, 32'd16);
    wait_done(2000, 0, ok);
    chk("t3_status", 64'(done_status), 64'd2);
    chk("t3_polls", 64'(polls), 64'd4);
    end_checks(st, np, bb_of(info_val), 1);

    // ERROR nonzero
    err_val = 64'h1;
    hit_poll = 0;
    build(64'hA0, 64'hB0, 64'h1_0000_00C0, 64'h9, 32'd8, 0, err_val, -1,
          st, np);
    do_start(64'hA0, 64'hB0, 64'h1_0000_00C0, 64'h9, 32'd8);
    wait_done(2000, 0, ok);
    chk("t4_status", 64'(done_status), 64'd1);
    end_checks(st, np, bb_of(info_val), 1);
    err_val = '0;

    // Abort while the NUM_LINES write is stalled
    info_val = 64'h0000_0000_0001_0000;
    hold_num = 1;
    build(64'hC0, 64'hD0, 64'hE0, 64'h1, 32'd4, 0, '0, 6, st, np);
    do_start(64'hC0, 64'hD0, 64'hE0, 64'h1, 32'd4);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_valid && req_addr == A_NUM) begin
        ok = 1;
        break;
      end
    end
    chk("t5_reach_num", 64'(ok), 64'd1);
    abort = 1'b1;
    repeat (3) @(negedge clk);
    hold_num = 0;
    wait_done(2000, 0, ok);
    chk("t5_status", 64'(done_status), 64'd3);
    end_checks(st, np, bb_of(info_val), 1);
    abort = 1'b0;

    // Random ready, random latency, start pulses while busy
    rdy_mode = 1;
    lat_lo = 1;
    lat_hi = 4;
    info_val = 64'h0000_0000_0000_0000;
    hit_poll = 1;
    build(64'hF00D, 64'hBEEF, 64'hCAFE_0000_1234, 64'h3, 32'd7, 1, '0,
          -1, st, np);
    do_start(64'hF00D, 64'hBEEF, 64'hCAFE_0000_1234, 64'h3, 32'd7);
    num_lines = 32'd0;
    wait_done(3000, 1, ok);
    end_checks(st, np, bb_of(info_val), 1);
    rdy_mode = 0;
    lat_lo = 2;
    lat_hi = 2;

    // Reset in the middle of polling
    hit_poll = -1;
    info_val = 64'h0000_0000_0002_0000;
    build(64'h10, 64'h20, 64'h30, 64'h40, 32'd16, -1, '0, -1, st, np);
    do_start(64'h10, 64'h20, 64'h30, 64'h40, 32'd16);
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (poll_idx >= 2) begin
        ok = 1;
        break;
      end
    end
    chk("t7_reach_poll", 64'(ok), 64'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    rsp_cnt = 0;
    rsp_valid = 1'b0;
    prev_hs = 0;
    prev_stall = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals();
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (req_valid || done) saw = 1;
    end
    chk("t7_quiet", 64'(saw), 64'd0);

    // Recovery run after reset
    info_val = 64'h0000_0000_0001_0000;
    hit_poll = 0;
    build(64'h77, 64'h88, 64'h99, 64'h5, 32'd4, 0, '0, -1, st, np);
    do_start(64'h77, 64'h88, 64'h99, 64'h5, 32'd4);
    wait_done(2000, 0, ok);
    chk("t8_bus_bytes", 64'(bus_bytes), 64'd64);
    end_checks(st, np, bb_of(info_val), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
